// File: rtl/fpio_fifo_reader_if.sv
// fpio_fifo_reader_if: bundles the FIFO pop port (data_en/data_ack) and the
// valid/ready output stream of the fpio FIFO reader.
// master = the reader itself, slave = the FIFO plus the downstream consumer.
interface fpio_fifo_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_BITS  = 4
);
    logic                  f_data_en;
    logic                  f_data_ack;
    logic [DATA_WIDTH-1:0] f_data;
    logic [FIFO_BITS:0]    f_avail;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output f_data_en,
        input  f_data_ack,
        input  f_data,
        input  f_avail,
        output m_valid,
        input  m_ready,
        output m_data
    );

    modport slave (
        input  f_data_en,
        output f_data_ack,
        output f_data,
        output f_avail,
        input  m_valid,
        output m_ready,
        input  m_data
    );
endinterface

// File: rtl/fpio_fifo_reader.sv
// fpio_fifo_reader: drains a programmed number of words from an fpio FIFO
// using the single-outstanding data_en/data_ack pop handshake, and delivers
// them on a valid/ready stream through a 2-entry output buffer.
// Optional ack timeout is compiled in with `define FPIO_FIFO_RD_TIMEOUT_EN.
module fpio_fifo_reader #(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_BITS      = 4,
    parameter int LEN_BITS       = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [LEN_BITS-1:0] len,
    output logic                busy,
    output logic                done,
    output logic                err,
    fpio_fifo_reader_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_WAIT
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [LEN_BITS-1:0]   remaining;
    logic                  done_r;
    logic                  done_nxt;
    logic                  load;
    logic                  push;
    logic                  pop;
    logic                  out_valid;
    logic [FIFO_BITS:0]    avail;

    // Two-entry output buffer; data storage is not reset, occupancy is.
    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            count;

    assign avail = bus.f_avail;

`ifdef FPIO_FIFO_RD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             timeout;
    logic             err_r;

    // Count cycles spent waiting for the ack; restarts each time WAIT is entered.
    always_ff @(posedge clk) begin
        if (!rstn || state != S_WAIT)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // The last permitted WAIT cycle is the one where the counter shows LIMIT-1.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Sticky error: set by a timeout, cleared by any start accepted in IDLE.
    always_ff @(posedge clk) begin
        if (!rstn)
            err_r <= 1'b0;
        else if (state == S_IDLE && start)
            err_r <= 1'b0;
        else if (timeout)
            err_r <= 1'b1;
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and pop-request decode; exactly one REQ cycle per pop.
    always_comb begin
        state_nxt     = state;
        done_nxt      = 1'b0;
        load          = 1'b0;
        push          = 1'b0;
        bus.f_data_en = 1'b0;
`ifdef FPIO_FIFO_RD_TIMEOUT_EN
        timeout       = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                // f_avail lags a pop by one cycle, so it is only trusted here.
                if (avail != '0 && count < 2'd2)
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                bus.f_data_en = 1'b1;
                state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                if (bus.f_data_ack) begin
                    push = 1'b1;
                    if (remaining == LEN_BITS'(1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_CHECK;
                    end
                end
`ifdef FPIO_FIFO_RD_TIMEOUT_EN
                else if (tmo_hit) begin
                    timeout   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Words still to pop: loaded on an accepted start, decremented per ack.
    always_ff @(posedge clk) begin
        if (!rstn)
            remaining <= '0;
        else if (load)
            remaining <= len;
        else if (push)
            remaining <= remaining - 1'b1;
    end

    // Registered done pulse, one cycle after the decision.
    always_ff @(posedge clk) begin
        if (!rstn)
            done_r <= 1'b0;
        else
            done_r <= done_nxt;
    end

    assign done = done_r;
    assign busy = (state != S_IDLE);

    // Capture the acked word into the buffer tail.
    always_ff @(posedge clk) begin
        if (push)
            buf_mem[tail] <= bus.f_data;
    end

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && bus.m_ready;

    // Buffer pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push)
                tail <= ~tail;
            if (pop)
                head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign bus.m_valid = out_valid;
    assign bus.m_data  = out_valid ? buf_mem[head] : '0;

endmodule

// File: tb/tb_fpio_fifo_reader.sv
// tb_fpio_fifo_reader: FIFO-side and consumer-side model for fpio_fifo_reader,
// with a transaction-level reference (expected buffer contents, outstanding
// pop, remaining words) compared against the DUT every cycle, plus directed
// scenarios with hand-computed cycle and data expectations.
module tb_fpio_fifo_reader;
    localparam int DW = 32;
    localparam int FB = 4;
    localparam int LB = 16;
`ifdef FPIO_FIFO_RD_TIMEOUT_EN
    localparam int TMO = 15;
`endif

    logic          clk   = 1'b0;
    logic          rstn  = 1'b0;
    logic          start = 1'b0;
    logic [LB-1:0] len   = '0;
    logic          busy;
    logic          done;
    logic          err;

    fpio_fifo_reader_if #(.DATA_WIDTH(DW), .FIFO_BITS(FB)) bus ();

    fpio_fifo_reader #(
        .DATA_WIDTH(DW),
        .FIFO_BITS(FB),
        .LEN_BITS(LB),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .len(len),
        .busy(busy),
        .done(done),
        .err(err),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [DW-1:0] fifo_q[$];
    bit            withhold  = 0;
    bit            stray     = 0;
    bit            en_neg    = 0;
    bit            ack_given = 0;

    initial begin
        bus.f_data_ack = 1'b0;
        bus.f_data     = '0;
        bus.f_avail    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_given && fifo_q.size() > 0)
                void'(fifo_q.pop_front());
            ack_given = 0;
            if (en_neg && !withhold && fifo_q.size() > 0) begin
                bus.f_data_ack = 1'b1;
                bus.f_data     = fifo_q[0];
                ack_given      = 1;
            end else if (stray) begin
                bus.f_data_ack = 1'b1;
                bus.f_data     = 32'hDEAD_BEEF;
            end else begin
                bus.f_data_ack = 1'b0;
                bus.f_data     = $urandom;
            end
            #1;
            bus.f_avail = (FB+1)'(fifo_q.size());
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    logic [DW-1:0] mbuf[$];
    logic [DW-1:0] hs_log[$];
    int            en_log[$];
    int            done_log[$];
    int            en_cnt = 0;
    int            done_cnt = 0;
    bit            chk_en = 0;
    bit            mbusy = 0, mdone = 0, merr = 0, outst = 0;
    bit            prev_busy = 0, prev_ack_acc = 0;
    int            prev_avail = 0, prev_cnt = 0;
    int            rem = 0, wcnt = 0;

    always @(negedge clk) begin
        bit legal;
        bit nbusy;
        bit ndone;
        bit acc;
        en_neg = bus.f_data_en;
        legal  = mbusy && !outst && prev_busy && !prev_ack_acc &&
                 (prev_avail != 0) && (prev_cnt < 2);
        if (chk_en) begin
            chk("busy", busy, mbusy);
            chk("done", done, mdone);
            chk("err", err, merr);
            chk("m_valid", bus.m_valid, mbuf.size() != 0);
            if (mbuf.size() != 0)
                chk("m_data", bus.m_data, mbuf[0]);
            if (bus.f_data_en)
                chk("en_legal", legal, 1'b1);
        end
        if (bus.f_data_en) begin
            en_log.push_back(cyc);
            en_cnt++;
        end
        if (done) begin
            done_log.push_back(cyc);
            done_cnt++;
        end
        if (bus.m_valid && bus.m_ready)
            hs_log.push_back(bus.m_data);

        if (!rstn) begin
            mbuf.delete();
            mbusy = 0; mdone = 0; merr = 0; outst = 0;
            prev_busy = 0; prev_ack_acc = 0; prev_avail = 0; prev_cnt = 0;
            rem = 0; wcnt = 0;
            chk_en = 1;
        end else begin
            nbusy = mbusy;
            ndone = 0;
            acc   = 0;
            prev_cnt   = mbuf.size();
            prev_avail = int'(bus.f_avail);
            prev_busy  = mbusy;
            if (mbuf.size() != 0 && bus.m_ready)
                void'(mbuf.pop_front());
            if (bus.f_data_ack && outst) begin
                mbuf.push_back(bus.f_data);
                rem--;
                outst = 0;
                acc   = 1;
                if (rem == 0) begin
                    nbusy = 0;
                    ndone = 1;
                end
            end else if (outst) begin
`ifdef FPIO_FIFO_RD_TIMEOUT_EN
                wcnt++;
                if (wcnt == TMO) begin
                    outst = 0;
                    nbusy = 0;
                    ndone = 1;
                    merr  = 1;
                end
`endif
            end
            if (bus.f_data_en) begin
                outst = 1;
                wcnt  = 0;
            end
            if (start && !mbusy) begin
                merr = 0;
                if (len == '0) begin
                    ndone = 1;
                end else begin
                    nbusy = 1;
                    rem   = int'(len);
                end
            end
            prev_ack_acc = acc;
            mbusy = nbusy;
            mdone = ndone;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = LB'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input int d0, input string nm);
        bit got = 0;
        for (int i = 0; i < maxc && !got; i++) begin
            tick();
            if (done_cnt > d0) got = 1;
        end
        chk({nm, "_done_seen"}, got, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, e0, h0, d0;
        logic [DW-1:0] exp_q[$];
        bus.m_ready = 1'b0;

        // Reset then idle
        rstn = 1'b0;
        ticks(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_en", bus.f_data_en, 0);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_mdata", bus.m_data, 0);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) fifo_q.push_back(32'hA0 + i);
        e0 = en_cnt;
        ticks(20);
        chk("idle_no_en", en_cnt - e0, 0);

        // Basic drain
        bus.m_ready = 1'b1;
        e0 = en_log.size(); h0 = hs_log.size(); d0 = done_cnt;
        t = cyc;
        do_start(4);
        wait_done(40, d0, "drain");
        ticks(3);
        chk("drain_pops", en_log.size() - e0, 4);
        for (int k = 0; k < 4; k++) begin
            chk("drain_en_cyc", en_log[e0+k], t + 2 + 3*k);
            chk("drain_data", hs_log[h0+k], 32'hA0 + k);
        end
        chk("drain_done_cyc", done_log[done_log.size()-1], t + 13);
        fifo_q.delete();
        ticks(2);

        // Backpressure
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) fifo_q.push_back(32'hB0 + i);
        tick();
        e0 = en_log.size(); h0 = hs_log.size(); d0 = done_cnt;
        do_start(5);
        ticks(25);
        chk("bp_stall_pops", en_log.size() - e0, 2);
        chk("bp_stall_busy", busy, 1);
        bus.m_ready = 1'b1;
        wait_done(60, d0, "bp");
        ticks(4);
        chk("bp_pops", en_log.size() - e0, 5);
        for (int k = 0; k < 5; k++) chk("bp_data", hs_log[h0+k], 32'hB0 + k);

        // Empty FIFO
        e0 = en_log.size(); h0 = hs_log.size(); d0 = done_cnt;
        do_start(2);
        ticks(10);
        chk("empty_no_en", en_log.size() - e0, 0);
        chk("empty_busy", busy, 1);
        fifo_q.push_back(32'hC0);
        fifo_q.push_back(32'hC1);
        wait_done(40, d0, "empty");
        ticks(4);
        chk("empty_data0", hs_log[h0], 32'hC0);
        chk("empty_data1", hs_log[h0+1], 32'hC1);

        // len=0
        e0 = en_log.size(); d0 = done_cnt;
        t = cyc;
        do_start(0);
        ticks(2);
        chk("len0_done_cyc", done_log[done_log.size()-1], t + 1);
        chk("len0_no_en", en_log.size() - e0, 0);

        // start while busy is ignored
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'hD0 + i);
        tick();
        e0 = en_log.size(); d0 = done_cnt;
        do_start(3);
        ticks(4);
        start = 1'b1; len = LB'(9);
        tick();
        start = 1'b0;
        wait_done(60, d0, "midstart");
        ticks(6);
        chk("midstart_pops", en_log.size() - e0, 3);
        chk("midstart_busy", busy, 0);

        // stray ack while idle is dropped
        stray = 1;
        tick();
        stray = 0;
        ticks(3);
        chk("stray_valid", bus.m_valid, 0);

        // reset mid-transfer
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hE0 + i);
        tick();
        do_start(4);
        ticks(6);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", bus.m_valid, 0);
        chk("midrst_done", done, 0);
        e0 = en_log.size();
        ticks(6);
        chk("midrst_no_en", en_log.size() - e0, 0);
        fifo_q.delete();
        bus.m_ready = 1'b1;
        ticks(2);

`ifdef FPIO_FIFO_RD_TIMEOUT_EN
        // ack timeout
        fifo_q.push_back(32'hF0);
        tick();
        withhold = 1;
        d0 = done_cnt; h0 = hs_log.size();
        do_start(1);
        wait_done(60, d0, "tmo");
        chk("tmo_done_cyc", done_log[done_log.size()-1], en_log[en_log.size()-1] + TMO + 1);
        ticks(1);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        withhold = 0;
        d0 = done_cnt;
        do_start(1);
        chk("tmo_err_clear", err, 0);
        wait_done(40, d0, "tmo_retry");
        ticks(4);
        chk("tmo_retry_data", hs_log[h0], 32'hF0);
`endif

        // randomized transfers
        for (int n = 0; n < 25; n++) begin
            int l, pushed;
            l = $urandom_range(1, 6);
            exp_q.delete();
            pushed = 0;
            h0 = hs_log.size();
            for (int i = 0; i < int'($urandom_range(0, l)); i++) begin
                logic [DW-1:0] w;
                w = $urandom;
                fifo_q.push_back(w);
                exp_q.push_back(w);
                pushed++;
            end
            d0 = done_cnt;
            do_start(l);
            for (int c = 0; c < 300 && done_cnt == d0; c++) begin
                bus.m_ready = 1'($urandom_range(0, 1));
                if (busy && $urandom_range(0, 9) == 0) begin
                    start = 1'b1;
                    len   = LB'($urandom_range(0, 20));
                end else begin
                    start = 1'b0;
                end
                if (pushed < l && $urandom_range(0, 2) == 0) begin
                    logic [DW-1:0] w;
                    w = $urandom;
                    fifo_q.push_back(w);
                    exp_q.push_back(w);
                    pushed++;
                end
                tick();
            end
            start = 1'b0;
            chk("rand_done", done_cnt > d0, 1'b1);
            bus.m_ready = 1'b1;
            ticks(4);
            chk("rand_count", hs_log.size() - h0, l);
            for (int k = 0; k < l; k++) chk("rand_order", hs_log[h0+k], exp_q[k]);
        end

        ticks(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpio_fifo_reader.md
# fpio_fifo_reader

Pop-side initiator for the fpio FIFO's consumer port. It drains a programmed number of words from an fpio FIFO using the data_en/data_ack pop handshake. Popped words are delivered on a valid/ready stream through a 2-entry output buffer. It sits between an fpio FIFO instance and any streaming consumer such as a DMA or pin serializer.

## Interface
Parameters:
- DATA_WIDTH, 32, FIFO word width
- FIFO_BITS, 4, FIFO depth log2; f_avail is FIFO_BITS+1 bits
- LEN_BITS, 16, transfer-length counter width
- TIMEOUT_CYCLES, 15, ack timeout limit (used only with FPIO_FIFO_RD_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a transfer of len words; ignored while busy
- len  in  LEN_BITS  words to pop; sampled on start; 0 = immediate done
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- err  out  1  sticky timeout flag; cleared by start
- f_data_en  out  1  pop request to FIFO
- f_data_ack  in  1  pop acknowledge from FIFO
- f_data  in  DATA_WIDTH  FIFO read data; valid in the f_data_ack cycle
- f_avail  in  FIFO_BITS+1  words held in FIFO
- m_valid  out  1  output word valid
- m_ready  in  1  consumer accepts the word
- m_data  out  DATA_WIDTH  output word (head of buffer)

## Operation
- States: IDLE, CHECK, REQ, WAIT.
- IDLE:
  - start with len=0 -> pulse done; stay in IDLE.
  - start with len!=0 -> load remaining=len, clear err, set busy, go to CHECK.
- CHECK:
  - Go to REQ when f_avail!=0 and buffer occupancy <2.
  - Otherwise stay in CHECK.
- REQ: drive f_data_en=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On f_data_ack, write f_data into the buffer tail and decrement remaining.
  - If remaining becomes 0 -> clear busy, pulse done next cycle, go to IDLE.
  - Otherwise go to CHECK.
- Only one pop is outstanding at a time. f_data_en is never asserted in WAIT or in the ack cycle.
- CHECK follows every ack because f_avail reflects a pop one cycle after the ack.
- Output buffer:
  - 2 entries with head/tail pointers and a 2-bit occupancy count.
  - m_valid = (count!=0).
  - A handshake (m_valid & m_ready) advances the head.
  - A push and a pop in the same cycle leave the count unchanged.
- The transfer completes when the last ack is captured, not when the last word drains; m_valid may remain high after done.
- f_data_ack outside WAIT is ignored and its data dropped.

## Timing
- Reset values: busy=0, done=0, err=0, f_data_en=0, m_valid=0, m_data=0, state=IDLE, buffer empty.
- start at cycle t -> CHECK at t+1 -> earliest f_data_en at t+2.
- f_data_en at cycle r -> f_data_ack expected at r+1. The word appears on m_data/m_valid at r+2.
- Peak throughput is 1 word per 3 cycles (REQ, WAIT, CHECK).
- done is asserted in the cycle after the final ack, for 1 cycle. busy falls in the same cycle done rises.
- m_data is registered from buffer storage and holds stable while m_valid=1 and m_ready=0.
- Reset mid-transfer returns to the reset state within one cycle.
  - Any ack arriving after reset is ignored.
  - Buffer contents are discarded.

## Configuration
- FPIO_FIFO_RD_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles elapse with no ack, set err=1, pulse done, clear busy, go to IDLE.
  - remaining is left unchanged.
- FPIO_FIFO_RD_TIMEOUT_EN undefined:
  - WAIT waits indefinitely.
  - err is tied to 0 and no counter logic exists.

## Test plan
- Reset then idle: rstn low 2 cycles -> all outputs 0. No f_data_en for 20 cycles while f_avail=5.
- Basic drain: FIFO preloaded 0xA0..0xA3, start len=4, m_ready=1.
  - m_data sequence A0,A1,A2,A3.
  - Exactly 4 f_data_en pulses, spaced 3 cycles apart.
  - done one cycle after the 4th ack.
- Backpressure: len=5, m_ready=0 -> exactly 2 pops, then CHECK stalls. Raising m_ready releases the remaining 3; the words arrive in order with none lost.
- Empty FIFO: start len=2, f_avail=0 for 10 cycles -> no f_data_en, busy=1. Pushing 2 words completes the transfer with done.
- len=0 and start while busy: start len=0 -> done at t+1 with no f_data_en. A start pulse mid-transfer -> ignored; remaining is unchanged.
- Timeout (macro defined, TIMEOUT_CYCLES=15): a pop with ack withheld -> err=1 and done after 15 WAIT cycles, then busy=0. The next start clears err.
